// File: rtl/updown_bounce_repeat_counter.sv
// Bouncing up/down counter (lo -> hi -> lo) with a run-time loadable bounds
// window and one value that can be held for extra cycles when entered in a chosen direction.
module updown_bounce_repeat_counter #(
  parameter int unsigned          WIDTH       = 3,
  parameter int unsigned          REPW        = 2,
  parameter logic [WIDTH-1:0]     DEF_LO      = '0,
  parameter logic [WIDTH-1:0]     DEF_HI      = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]     DEF_REP_VAL = WIDTH'(4),
  parameter logic [REPW-1:0]      DEF_REP_CNT = REPW'(1),
  parameter logic                 DEF_REP_DIR = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             cfg_load_i,
  input  logic [WIDTH-1:0] cfg_lo_i,
  input  logic [WIDTH-1:0] cfg_hi_i,
  input  logic [WIDTH-1:0] cfg_rep_val_i,
  input  logic [REPW-1:0]  cfg_rep_cnt_i,
  input  logic             cfg_rep_dir_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             dir_up_o,
  output logic             rep_active_o,
  output logic             turn_o,
  output logic             cfg_err_o
);

  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, repVal_q, repVal_d;
  logic [REPW-1:0]  repCnt_q, repCnt_d;
  logic             repDir_q, repDir_d;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dirUp_q, dirUp_d;
  logic [REPW-1:0]  holdLeft_q, holdLeft_d;
  logic             repActive_q, repActive_d;
  logic             turn_q, turn_d;
  logic             cfgErr_q, cfgErr_d;

  logic [WIDTH-1:0] stepVal;
  logic             advance;

  // dirUp flips exactly when cnt reaches a bound, so +/-1 can never leave [lo,hi].
  assign stepVal = dirUp_q ? cnt_q + 1'b1 : cnt_q - 1'b1;

  always_comb begin
    lo_d        = lo_q;
    hi_d        = hi_q;
    repVal_d    = repVal_q;
    repCnt_d    = repCnt_q;
    repDir_d    = repDir_q;
    cnt_d       = cnt_q;
    dirUp_d     = dirUp_q;
    holdLeft_d  = holdLeft_q;
    repActive_d = repActive_q;
    turn_d      = 1'b0;
    cfgErr_d    = 1'b0;
    advance     = 1'b0;

    if (cfg_load_i) begin
      if (cfg_lo_i < cfg_hi_i) begin
        lo_d        = cfg_lo_i;
        hi_d        = cfg_hi_i;
        repVal_d    = cfg_rep_val_i;
        repCnt_d    = cfg_rep_cnt_i;
        repDir_d    = cfg_rep_dir_i;
        cnt_d       = cfg_lo_i;
        dirUp_d     = 1'b1;
        holdLeft_d  = '0;
        repActive_d = 1'b0;
      end else begin
        cfgErr_d = 1'b1;
        advance  = en_i;
      end
    end else begin
      advance = en_i;
    end

    if (advance) begin
      if (holdLeft_q != '0) begin
        holdLeft_d  = holdLeft_q - 1'b1;
        repActive_d = 1'b1;
      end else begin
        cnt_d       = stepVal;
        repActive_d = 1'b0;
        if (stepVal == hi_q) begin
          dirUp_d = 1'b0;
        end else if (stepVal == lo_q) begin
          dirUp_d = 1'b1;
        end
        turn_d = (stepVal == lo_q) || (stepVal == hi_q);
        // The first cycle at the repeat value is a normal step; the hold follows it.
        if ((stepVal == repVal_q) && (dirUp_q == repDir_q) && (repCnt_q != '0)) begin
          holdLeft_d = repCnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lo_q        <= DEF_LO;
      hi_q        <= DEF_HI;
      repVal_q    <= DEF_REP_VAL;
      repCnt_q    <= DEF_REP_CNT;
      repDir_q    <= DEF_REP_DIR;
      cnt_q       <= DEF_LO;
      dirUp_q     <= 1'b1;
      holdLeft_q  <= '0;
      repActive_q <= 1'b0;
      turn_q      <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      repVal_q    <= repVal_d;
      repCnt_q    <= repCnt_d;
      repDir_q    <= repDir_d;
      cnt_q       <= cnt_d;
      dirUp_q     <= dirUp_d;
      holdLeft_q  <= holdLeft_d;
      repActive_q <= repActive_d;
      turn_q      <= turn_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign dir_up_o     = dirUp_q;
  assign rep_active_o = repActive_q;
  assign turn_o       = turn_q;
  assign cfg_err_o    = cfgErr_q;

endmodule
